// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin burst memory arbitrator.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BURST_XFER = 2'd1,
    DONE       = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational priority select: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          grant_valid
);

  logic [PW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbitrator_rr.sv
// Burst mover between N_CH inbound/outbound FIFOs and per-channel circular RAM
// regions, with watermark-gated requests and round-robin over 2*N_CH requesters.
module mem_arbitrator_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REGION_AW = 10,
  parameter int unsigned FIFO_CW   = 11,
  parameter int unsigned BURST     = 16,
  parameter int unsigned MEM_AW    = 23
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CH-1:0]                 chan_enable,
  input  logic [N_CH-1:0]                 chan_clear,
  input  logic [N_CH*FIFO_CW-1:0]         in_count,
  input  logic [N_CH*DATA_W-1:0]          in_data,
  output logic [N_CH-1:0]                 in_rd,
  input  logic [N_CH*FIFO_CW-1:0]         out_space,
  output logic [DATA_W-1:0]               out_data,
  output logic [N_CH-1:0]                 out_wr,
  output logic [MEM_AW-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic                            mem_req,
  output logic                            mem_we,
  input  logic                            mem_ack,
  output logic [N_CH*32-1:0]              wr_total,
  output logic [N_CH*32-1:0]              rd_total,
  output logic [N_CH*(REGION_AW+1)-1:0]   fill
);

  localparam int unsigned CH_W   = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
  localparam int unsigned N_REQ  = 2 * N_CH;
  localparam int unsigned GW     = clog2(N_REQ);
  localparam int unsigned CNT_W  = clog2(BURST) + 1;
  localparam int unsigned FILL_W = REGION_AW + 1;

  localparam logic [FIFO_CW-1:0] BURST_CNT  = FIFO_CW'(BURST);
  localparam logic [FILL_W-1:0]  BURST_FILL = FILL_W'(BURST);
  localparam logic [FILL_W-1:0]  WR_LIMIT   = FILL_W'((1 << REGION_AW) - BURST);
  localparam logic [CNT_W-1:0]   LAST_WORD  = CNT_W'(BURST - 1);

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] req;
  logic [GW-1:0]    arb_grant;
  logic             arb_valid;

  logic [CH_W-1:0]  cur_ch;
  logic             cur_we;
  logic             xfer;
  logic             xfer_ack;
  logic             done;

  logic [REGION_AW-1:0] wr_ptr_a [N_CH];
  logic [REGION_AW-1:0] rd_ptr_a [N_CH];

  // Even requester index = write, odd = read; channel is the index over two.
  assign cur_ch   = CH_W'(grant_q >> 1);
  assign cur_we   = ~grant_q[0];
  assign xfer     = (state_q == BURST_XFER);
  assign xfer_ack = xfer & mem_ack;
  assign done     = (state_q == DONE);

  rr_arbiter #(
    .N  (N_REQ),
    .PW (GW)
  ) u_rr_arbiter (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          cnt_d   = '0;
          state_d = BURST_XFER;
        end
      end
      BURST_XFER: begin
        if (mem_ack) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        rr_ptr_d = grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [REGION_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [REGION_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [31:0]          wr_tot_q, wr_tot_d;
    logic [31:0]          rd_tot_q, rd_tot_d;
    logic                 clr_pend_q, clr_pend_d;
    logic                 sel;

    assign sel = (state_q != IDLE) && (cur_ch == CH_W'(c));

    assign req[2*c]   = chan_enable[c] && (in_count[c*FIFO_CW +: FIFO_CW] >= BURST_CNT)
                        && (fill_q <= WR_LIMIT);
    assign req[2*c+1] = chan_enable[c] && (fill_q >= BURST_FILL)
                        && (out_space[c*FIFO_CW +: FIFO_CW] >= BURST_CNT);

    // A clear arriving while this channel owns the burst is held until DONE,
    // where it overrides the burst's own fill update.
    always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      wr_tot_d   = wr_tot_q;
      rd_tot_d   = rd_tot_q;
      clr_pend_d = clr_pend_q;
      if (sel && xfer_ack) begin
        if (cur_we) wr_ptr_d = wr_ptr_q + 1'b1;
        else        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (sel && done) begin
        if (cur_we) begin
          fill_d   = fill_q + BURST_FILL;
          wr_tot_d = wr_tot_q + 32'(BURST);
        end else begin
          fill_d   = fill_q - BURST_FILL;
          rd_tot_d = rd_tot_q + 32'(BURST);
        end
        if (clr_pend_q || chan_clear[c]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          fill_d   = '0;
        end
        clr_pend_d = 1'b0;
      end else if (chan_clear[c]) begin
        if (sel) begin
          clr_pend_d = 1'b1;
        end else begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          fill_d   = '0;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fill_q     <= '0;
        wr_tot_q   <= '0;
        rd_tot_q   <= '0;
        clr_pend_q <= 1'b0;
      end else begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        fill_q     <= fill_d;
        wr_tot_q   <= wr_tot_d;
        rd_tot_q   <= rd_tot_d;
        clr_pend_q <= clr_pend_d;
      end
    end

    assign wr_ptr_a[c]                    = wr_ptr_q;
    assign rd_ptr_a[c]                    = rd_ptr_q;
    assign fill[c*FILL_W +: FILL_W]       = fill_q;
    assign wr_total[c*32 +: 32]           = wr_tot_q;
    assign rd_total[c*32 +: 32]           = rd_tot_q;
  end

  assign mem_req = xfer;
  assign mem_we  = xfer & cur_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    out_data  = '0;
    in_rd     = '0;
    out_wr    = '0;
    if (xfer) begin
      mem_addr[REGION_AW-1:0]     = cur_we ? wr_ptr_a[cur_ch] : rd_ptr_a[cur_ch];
      mem_addr[REGION_AW +: CH_W] = cur_ch;
      if (cur_we) mem_wdata = in_data[cur_ch*DATA_W +: DATA_W];
      if (mem_ack) begin
        if (cur_we) begin
          in_rd[cur_ch] = 1'b1;
        end else begin
          out_wr[cur_ch] = 1'b1;
          out_data       = mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbitrator_rr.sv
// Randomised bench for mem_arbitrator_rr: the bench plays FIFOs and RAM and
// predicts grants, addresses, data order, fills and totals from a channel-level model.
module tb_mem_arbitrator_rr;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int RAW = 5;
  localparam int FCW = 11;
  localparam int B   = 16;
  localparam int MAW = 23;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         chan_enable, chan_clear;
  logic [N*FCW-1:0]     in_count, out_space;
  logic [N*DW-1:0]      in_data;
  logic [N-1:0]         in_rd, out_wr;
  logic [DW-1:0]        out_data, mem_wdata, mem_rdata;
  logic [MAW-1:0]       mem_addr;
  logic                 mem_req, mem_we, mem_ack;
  logic [N*32-1:0]      wr_total, rd_total;
  logic [N*(RAW+1)-1:0] fill;

  mem_arbitrator_rr #(
    .N_CH(N), .DATA_W(DW), .REGION_AW(RAW), .FIFO_CW(FCW), .BURST(B), .MEM_AW(MAW)
  ) dut (
    .clk(clk), .reset(reset), .chan_enable(chan_enable), .chan_clear(chan_clear),
    .in_count(in_count), .in_data(in_data), .in_rd(in_rd), .out_space(out_space),
    .out_data(out_data), .out_wr(out_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .wr_total(wr_total), .rd_total(rd_total), .fill(fill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          m_fill[N], m_wp[N], m_rp[N], m_incnt[N], m_space[N], m_seq[N];
  bit          m_pend[N];
  logic [31:0] m_wt[N], m_rt[N];
  int          m_rr;
  logic [DW-1:0] m_q[N][$];
  logic [DW-1:0] ram [0:127];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] head(int c);
    return DW'((c << 12) | (m_seq[c] & 'hfff));
  endfunction

  function automatic int dut_fill(int c);
    return int'(fill[c*(RAW+1) +: RAW+1]);
  endfunction

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      in_count[c*FCW +: FCW]  = FCW'(m_incnt[c]);
      out_space[c*FCW +: FCW] = FCW'(m_space[c]);
      in_data[c*DW +: DW]     = head(c);
    end
  endtask

  function automatic int model_pick();
    for (int i = 0; i < 2*N; i++) begin
      int r, c;
      r = (m_rr + i) % (2*N);
      c = r / 2;
      if (r % 2 == 0) begin
        if (chan_enable[c] && m_incnt[c] >= B && m_fill[c] <= (1 << RAW) - B) return r;
      end else begin
        if (chan_enable[c] && m_fill[c] >= B && m_space[c] >= B) return r;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_fill[c] = 0; m_wp[c] = 0; m_rp[c] = 0; m_wt[c] = 0; m_rt[c] = 0;
      m_pend[c] = 0; m_incnt[c] = 0; m_space[c] = 0;
      m_q[c].delete();
    end
    m_rr = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int c = 0; c < N; c++) begin
      n_cmp++;
      if (dut_fill(c) != m_fill[c] || wr_total[c*32 +: 32] !== m_wt[c] ||
          rd_total[c*32 +: 32] !== m_rt[c]) begin
        n_err++;
        $display("FAIL %s ch%0d: fill/wr/rd got %0d/%0d/%0d want %0d/%0d/%0d", tag, c,
                 dut_fill(c), wr_total[c*32 +: 32], rd_total[c*32 +: 32],
                 m_fill[c], m_wt[c], m_rt[c]);
      end
    end
  endtask

  // Serves one burst as FIFO/RAM; obs is the requester index seen on the bus.
  task automatic serve_burst(input int mode, input int clr_ch, input int clr_at,
                             input int rst_at, output int start_cyc, output int obs,
                             output int len);
    int waited, acks, k, c, pick, exp_addr;
    bit we, ack, pulsed;
    logic [N-1:0]  es;
    logic [DW-1:0] exp_d;
    start_cyc = -1; obs = -1; len = 0; waited = 0; pulsed = 0;
    do begin
      @(negedge clk); drive(); chan_clear = '0; mem_ack = 1'b0; #1;
      waited++;
    end while (!mem_req && waited < 20);
    n_cmp++;
    if (!mem_req) begin
      n_err++;
      $display("FAIL burst_start: mem_req 0 after 20 cycles, want requester %0d", model_pick());
      return;
    end
    start_cyc = cyc;
    pick = model_pick();
    obs  = int'(mem_addr[RAW +: 2]) * 2 + (mem_we ? 0 : 1);
    n_cmp++;
    if (obs != pick) begin
      n_err++;
      $display("FAIL grant: requester %0d want %0d", obs, pick);
      return;
    end
    c = pick / 2; we = (pick % 2 == 0);
    acks = 0; k = 0;
    while (acks < B && k < 200) begin
      if (k > 0) begin
        @(negedge clk); drive(); chan_clear = '0;
      end
      if (clr_ch >= 0 && acks == clr_at && !pulsed) begin
        chan_clear[clr_ch] = 1'b1; m_pend[clr_ch] = 1'b1; pulsed = 1;
      end
      if (rst_at >= 0 && acks == rst_at) begin
        reset = 1'b0; #1;
        n_cmp++;
        if ({mem_req, mem_we, in_rd, out_wr} !== '0 || mem_addr !== '0 ||
            mem_wdata !== '0 || out_data !== '0) begin
          n_err++;
          $display("FAIL async_reset_outputs: req=%b we=%b rd=%b wr=%b addr=%h wdata=%h od=%h want all 0",
                   mem_req, mem_we, in_rd, out_wr, mem_addr, mem_wdata, out_data);
        end
        n_cmp++;
        if (fill !== '0 || wr_total !== '0 || rd_total !== '0) begin
          n_err++;
          $display("FAIL async_reset_regs: fill=%h wr=%h rd=%h want 0", fill, wr_total, rd_total);
        end
        model_reset();
        return;
      end
      ack = (mode == 1) ? 1'b1 : (mode == 2) ? 1'(k % 2) : 1'($urandom_range(0, 1));
      mem_ack   = ack;
      exp_addr  = (c << RAW) | (we ? m_wp[c] : m_rp[c]);
      mem_rdata = we ? DW'($urandom) : ram[mem_addr[6:0]];
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== MAW'(exp_addr)) begin
        n_err++;
        $display("FAIL xfer_addr: req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, exp_addr);
      end
      if (we) begin
        n_cmp++;
        if (mem_wdata !== head(c)) begin
          n_err++;
          $display("FAIL wdata: got %h want %h", mem_wdata, head(c));
        end
      end
      es = ack ? (N'(1) << c) : '0;
      n_cmp++;
      if (in_rd !== (we ? es : '0) || out_wr !== (we ? '0 : es)) begin
        n_err++;
        $display("FAIL strobes: in_rd=%b out_wr=%b want in_rd=%b out_wr=%b",
                 in_rd, out_wr, we ? es : '0, we ? '0 : es);
      end
      if (ack) begin
        if (we) begin
          ram[exp_addr[6:0]] = head(c);
          m_q[c].push_back(head(c));
          m_seq[c]++; m_incnt[c]--;
          m_wp[c] = (m_wp[c] + 1) % (1 << RAW);
        end else begin
          exp_d = (m_q[c].size() > 0) ? m_q[c].pop_front() : '0;
          n_cmp++;
          if (out_data !== exp_d) begin
            n_err++;
            $display("FAIL read_data: out_data=%h want %h", out_data, exp_d);
          end
          m_space[c]--;
          m_rp[c] = (m_rp[c] + 1) % (1 << RAW);
        end
        acks++;
      end
      k++;
    end
    len = k;
    n_cmp++;
    if (acks < B) begin
      n_err++;
      $display("FAIL burst_acks: only %0d acks in %0d cycles, want %0d", acks, k, B);
    end
    @(negedge clk); drive(); chan_clear = '0; mem_ack = 1'b0; #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL done_req: mem_req=%b want 0", mem_req);
    end
    if (we) begin m_fill[c] += B; m_wt[c] += B; end
    else    begin m_fill[c] -= B; m_rt[c] += B; end
    if (m_pend[c]) begin
      m_fill[c] = 0; m_wp[c] = 0; m_rp[c] = 0; m_pend[c] = 0;
      m_q[c].delete();
    end
    m_rr = (pick + 1) % (2*N);
    @(negedge clk); drive(); #1;
    check_regs("after_burst");
  endtask

  task automatic expect_no_burst(input int n, input string tag);
    bit seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk); drive(); chan_clear = '0; mem_ack = 1'b0; #1;
      if (mem_req) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL %s: mem_req seen=1 want 0", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #2; reset = 1'b0; #1;
    model_reset(); drive();
    n_cmp++;
    if ({mem_req, mem_we, in_rd, out_wr} !== '0 || mem_addr !== '0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b we=%b rd=%b wr=%b addr=%h want 0",
               mem_req, mem_we, in_rd, out_wr, mem_addr);
    end
    check_regs("reset_regs");
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single_write();
    int s, o, l;
    chan_enable = '1;
    for (int c = 0; c < N; c++) begin m_incnt[c] = 0; m_space[c] = 0; end
    m_incnt[1] = 16;
    serve_burst(1, -1, 0, -1, s, o, l);
    expect_no_burst(6, "idle_after_write");
  endtask

  task automatic test_single_read();
    int s, o, l;
    m_space[1] = 64;
    serve_burst(1, -1, 0, -1, s, o, l);
  endtask

  task automatic test_ack_toggle();
    int s, o, l;
    m_incnt[1] = 16;
    serve_burst(2, -1, 0, -1, s, o, l);
    n_cmp++;
    if (l != 32) begin
      n_err++;
      $display("FAIL toggle_len: burst took %0d cycles want 32", l);
    end
  endtask

  task automatic test_reset_mid_burst();
    int s, o, l;
    m_space[1] = 64;
    serve_burst(1, -1, 0, 5, s, o, l);
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_round_robin();
    int s, o, l, prev;
    int exp_ord[8] = '{0, 2, 4, 6, 0, 2, 4, 6};
    chan_enable = '1;
    for (int c = 0; c < N; c++) begin m_incnt[c] = 32; m_space[c] = 0; end
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      serve_burst(1, -1, 0, -1, s, o, l);
      n_cmp++;
      if (o != exp_ord[i]) begin
        n_err++;
        $display("FAIL rr_order[%0d]: requester %0d want %0d", i, o, exp_ord[i]);
      end
      if (prev >= 0) begin
        n_cmp++;
        if (s - prev != B + 2) begin
          n_err++;
          $display("FAIL burst_period[%0d]: %0d cycles want %0d", i, s - prev, B + 2);
        end
      end
      prev = s;
    end
  endtask

  task automatic test_full_region();
    m_incnt[0] = 100;
    expect_no_burst(12, "full_region_write");
  endtask

  task automatic test_wrap();
    int s, o, l;
    chan_enable = 4'b0001;
    m_space[0] = 1000;
    m_incnt[0] = 100;
    for (int i = 0; i < 6; i++) serve_burst(3, -1, 0, -1, s, o, l);
  endtask

  task automatic test_clear();
    int s, o, l;
    chan_enable = 4'b0100;
    m_space[2] = 100;
    serve_burst(3, 2, 5, -1, s, o, l);
    m_incnt[2] = 16;
    serve_burst(1, -1, 0, -1, s, o, l);
    serve_burst(1, -1, 0, -1, s, o, l);
    chan_enable = '0;
    @(negedge clk); drive(); chan_clear = 4'b1000; #1;
    @(negedge clk); chan_clear = '0;
    m_fill[3] = 0; m_wp[3] = 0; m_rp[3] = 0; m_q[3].delete();
    #1;
    check_regs("idle_clear");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    chan_enable = '0; chan_clear = '0; mem_ack = 1'b0; mem_rdata = '0;
    in_count = '0; out_space = '0; in_data = '0;
    for (int i = 0; i < 128; i++) ram[i] = '0;
    for (int c = 0; c < N; c++) m_seq[c] = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_ack_toggle();
    test_reset_mid_burst();
    test_round_robin();
    test_full_region();
    test_wrap();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
